// File: rtl/log2_req_sched.sv
// Round-robin scheduler sharing one iterative log2 unit among NREQ requesters, one op in flight.
// Optional macro LOG2_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT_CYC cycles without u_done.
module log2_req_sched #(
  parameter int NREQ        = 4,
  parameter int XW          = 8,
  parameter int RW          = 11,
  parameter int TIMEOUT_CYC = 64,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XW-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [RW-1:0]        rsp_log2,
  output logic                 rsp_err,
  output logic                 u_start,
  output logic [XW-1:0]        u_x,
  input  logic                 u_done,
  input  logic [RW-1:0]        u_log2
);

  if (NREQ < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("log2_req_sched: NREQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state, w_state_next;
  logic [IDW-1:0]   r_rr_ptr, w_rr_next;
  logic [IDW-1:0]   r_id, w_id_next;
  logic [XW-1:0]    r_x, w_x_next;
  logic [RW-1:0]    r_log2, w_log2_next;
  logic             r_err, w_err_next;

  logic [XW-1:0]    w_lane_x [NREQ];
  logic [IDW-1:0]   w_win;
  logic [XW-1:0]    w_win_x;
  logic             w_found;
  int               w_idx;

`ifdef LOG2_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]    r_cnt, w_cnt_next;
`endif

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign w_lane_x[gi] = req_x[gi*XW +: XW];
  end

  // Walk from the farthest candidate to the nearest so the last hit is the rr winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % NREQ;
      if (req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  assign w_win_x = w_lane_x[w_win];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= IDW'(NREQ - 1);
      r_id     <= '0;
      r_x      <= '0;
      r_log2   <= '0;
      r_err    <= 1'b0;
`ifdef LOG2_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_next;
      r_id     <= w_id_next;
      r_x      <= w_x_next;
      r_log2   <= w_log2_next;
      r_err    <= w_err_next;
`ifdef LOG2_TIMEOUT_EN
      r_cnt    <= w_cnt_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr_ptr;
    w_id_next    = r_id;
    w_x_next     = r_x;
    w_log2_next  = r_log2;
    w_err_next   = r_err;
    req_ready    = '0;
    u_start      = 1'b0;
    rsp_valid    = 1'b0;
`ifdef LOG2_TIMEOUT_EN
    w_cnt_next   = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_win] = 1'b1;
          w_id_next        = w_win;
          w_x_next         = w_win_x;
          // log2(0) is undefined: answer directly with an error, unit untouched.
          if (w_win_x == '0) begin
            w_log2_next  = '0;
            w_err_next   = 1'b1;
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        u_start      = 1'b1;
        w_state_next = S_WAIT;
`ifdef LOG2_TIMEOUT_EN
        w_cnt_next   = '0;
`endif
      end
      S_WAIT: begin
        if (u_done) begin
          w_log2_next  = u_log2;
          w_err_next   = 1'b0;
          w_state_next = S_RESP;
        end
`ifdef LOG2_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          w_log2_next  = '0;
          w_err_next   = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
`endif
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rr_next    = r_id;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign u_x      = r_x;
  assign rsp_id   = r_id;
  assign rsp_log2 = r_log2;
  assign rsp_err  = r_err;

endmodule

// File: tb/tb_log2_req_sched.sv
// Self-checking bench for log2_req_sched: table of transactions, scoreboard of expected responses,
// plus hand-written dead-unit / mid-op reset sequences.
module tb_log2_req_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [10:0] rsp_log2;
  logic        rsp_err;
  logic        u_start;
  logic [7:0]  u_x;
  logic        u_done;
  logic [10:0] u_log2;

  log2_req_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_log2  (rsp_log2),
    .rsp_err   (rsp_err),
    .u_start   (u_start),
    .u_x       (u_x),
    .u_done    (u_done),
    .u_log2    (u_log2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] xs;
    int          lat;
    int          hold;
    logic [3:0]  ready;
    logic [1:0]  id;
    logic [10:0] log2;
    logic        err;
    int          rsp_cyc;
    int          starts;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [10:0] log2;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  vec_t post_vec;

  int n_vec  = 0;
  int n_miss = 0;

  bit          u_busy;
  int          u_t0;
  int          u_lat;
  logic [7:0]  u_xcap;

  // Behavioural log2 unit: exponent = msb - 3 (5.3 input), fraction = next six bits.
  function automatic logic [10:0] unit_model(input logic [7:0] x);
    int          p;
    logic [15:0] t;
    p = 0;
    for (int b = 0; b < 8; b++) if (x[b]) p = b;
    t = 16'(x) << (7 - p);
    return {5'(p - 3), t[6:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unit_drive(input int c);
    if (u_busy && u_lat >= 0 && c == u_t0 + u_lat) begin
      u_done = 1'b1;
      u_log2 = unit_model(u_xcap);
      u_busy = 1'b0;
    end else begin
      u_done = 1'b0;
      u_log2 = '0;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          n_start;
    int          n_rsp;
    int          first_rsp;
    bit          done;
    bit          extra_ready;
    bit          unstable;
    logic [1:0]  s_id;
    logic [10:0] s_log2;
    logic        s_err;
    exp_t        e;
    n_start = 0; n_rsp = 0; first_rsp = -1;
    done = 1'b0; extra_ready = 1'b0; unstable = 1'b0;
    s_id = '0; s_log2 = '0; s_err = 1'b0;
    u_busy = 1'b0;
    u_lat  = v.lat;
    req_x  = v.xs;
    for (int c = 0; c < 200 && !done; c++) begin
      req_valid = v.valid;
      rsp_ready = (n_rsp >= v.hold);
      unit_drive(c);
      #1;
      if (c == 0) begin
        chk({tag, " grant"}, 32'(req_ready), 32'(v.ready));
        chk({tag, " idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
        if (req_ready != '0) sb.push_back('{v.id, v.log2, v.err});
      end else if (req_ready != '0) begin
        extra_ready = 1'b1;
      end
      if (u_start) begin
        n_start++;
        u_busy = 1'b1;
        u_t0   = c;
        u_xcap = u_x;
        chk({tag, " u_x"}, 32'(u_x), 32'(v.xs[v.id*8 +: 8]));
      end
      if (rsp_valid) begin
        if (n_rsp == 0) begin
          first_rsp = c;
          s_id = rsp_id; s_log2 = rsp_log2; s_err = rsp_err;
        end else if ({rsp_id, rsp_log2, rsp_err} !== {s_id, s_log2, s_err}) begin
          unstable = 1'b1;
        end
        n_rsp++;
        if (rsp_ready) begin
          done = 1'b1;
          if (sb.size() == 0) begin
            chk({tag, " rsp_without_grant"}, 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk({tag, " rsp_id"},   32'(rsp_id),   32'(e.id));
            chk({tag, " rsp_log2"}, 32'(rsp_log2), 32'(e.log2));
            chk({tag, " rsp_err"},  32'(rsp_err),  32'(e.err));
          end
          req_valid = '0;
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    u_done    = 1'b0;
    chk({tag, " handshake_done"}, 32'(done), 32'd1);
    chk({tag, " rsp_latency"}, 32'(first_rsp), 32'(v.rsp_cyc));
    chk({tag, " u_start_count"}, 32'(n_start), 32'(v.starts));
    chk({tag, " busy_req_ready"}, 32'(extra_ready), 32'd0);
    chk({tag, " rsp_stable"}, 32'(unstable), 32'd0);
    sb.delete();
  endtask

  initial begin
    int  n_start;
    bit  any_rsp;

    //          valid     xs            lat hold ready    id    log2     err rsp starts
    vecs[0] = '{4'b0001, 32'h0000_0040, 10, 0, 4'b0001, 2'd0, 11'h0C0, 1'b0, 12, 1};
    vecs[1] = '{4'b1111, 32'h60FF_100C,  1, 0, 4'b0010, 2'd1, 11'h040, 1'b0,  3, 1};
    vecs[2] = '{4'b1111, 32'h60FF_100C,  4, 0, 4'b0100, 2'd2, 11'h13F, 1'b0,  6, 1};
    vecs[3] = '{4'b1111, 32'h60FF_100C,  2, 5, 4'b1000, 2'd3, 11'h0E0, 1'b0,  4, 1};
    vecs[4] = '{4'b1111, 32'h60FF_100C,  7, 0, 4'b0001, 2'd0, 11'h020, 1'b0,  9, 1};
    vecs[5] = '{4'b0100, 32'h1100_1122,  5, 0, 4'b0100, 2'd2, 11'h000, 1'b1,  1, 0};
    vecs[6] = '{4'b0011, 32'h7788_4001,  3, 0, 4'b0001, 2'd0, 11'h740, 1'b0,  5, 1};
    vecs[7] = '{4'b1001, 32'hFF55_5510,  1, 0, 4'b1000, 2'd3, 11'h13F, 1'b0,  3, 1};
    vecs[8] = '{4'b1010, 32'h3300_0C00,  5, 2, 4'b0010, 2'd1, 11'h020, 1'b0,  7, 1};
    post_vec = '{4'b1111, 32'h60FF_100C, 3, 0, 4'b0001, 2'd0, 11'h020, 1'b0,  5, 1};

    rst_n = 1'b0; req_valid = '0; req_x = '0; rsp_ready = 1'b0;
    u_done = 1'b0; u_log2 = '0; u_busy = 1'b0; u_t0 = 0; u_lat = 0; u_xcap = '0;
    #1;
    chk("reset outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_log2, rsp_err, u_start, u_x}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      $display("vec%0d: id=%0d log2=%03h err=%0d done", i, vecs[i].id, vecs[i].log2, vecs[i].err);
    end

`ifdef LOG2_TIMEOUT_EN
    run_vec('{4'b0001, 32'h0000_0040, -1, 0, 4'b0001, 2'd0, 11'h000, 1'b1, 66, 1}, "timeout");
    $display("timeout: abort response checked");
`endif

    // Dead unit: WAIT must not exit within 40 cycles (no response at all without the timeout).
    u_lat = -1; u_busy = 1'b0; req_x = 32'h0000_0040; n_start = 0; any_rsp = 1'b0;
    for (int c = 0; c < 40; c++) begin
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      rsp_ready = 1'b1;
      unit_drive(c);
      #1;
      if (c == 0) chk("dead grant", 32'(req_ready), 32'b0001);
      if (u_start) begin n_start++; u_busy = 1'b1; u_t0 = c; u_xcap = u_x; end
      if (rsp_valid) any_rsp = 1'b1;
      @(negedge clk);
    end
    chk("dead no_rsp", 32'(any_rsp), 32'd0);
    chk("dead u_start_count", 32'(n_start), 32'd1);
    chk("dead u_x held", 32'(u_x), 32'h40);
    $display("dead unit: no response over 40 cycles");

    // Asynchronous reset in the middle of WAIT.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop reset outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_log2, rsp_err, u_start, u_x}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    u_done = 1'b1; u_log2 = 11'h7FF;
    #1;
    chk("stray done rsp_valid", 32'({rsp_valid, u_start}), 32'd0);
    @(negedge clk);
    u_done = 1'b0; u_log2 = '0;
    #1;
    chk("after stray done idle", 32'({rsp_valid, u_start, req_ready}), 32'd0);
    @(negedge clk);
    $display("mid-op reset: outputs cleared, stray u_done ignored");

    run_vec(post_vec, "post_reset");
    $display("post_reset: id=%0d log2=%03h err=%0d done", post_vec.id, post_vec.log2, post_vec.err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
